sdr_job_scheduler: RTL
======================

SDR_JOB_SCHEDULER -- requirements
Module: sdr_job_scheduler

Interface
REQ-001 SHALL have: clk_i  in  1  clock; all logic on rising edge.
REQ-002 SHALL have: rst_ni  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have: req_i  in  4  per-requester job request; level, held high until done_o/err_o for that requester.
REQ-004 SHALL have: gnt_o  out  4  one-hot grant; grantee owns the SDR register mux while high.
REQ-005 SHALL have: done_o  out  4  one-cycle completion pulse to grantee.
REQ-006 SHALL have: err_o  out  4  one-cycle failure pulse to grantee.
REQ-007 SHALL have: sdr_control_o  out  32  to SDR datapath; bit0 = start; bits 31:1 = 0.
REQ-008 SHALL have: sdr_status_i  in  32  from SDR datapath; bit31 done, bit30 fifo-full error, bit29 state error, bits 7:0 index count.
REQ-009 SHALL have: timeout_cfg_i  in  16  WAIT cycle limit; 0 = timeout disabled.
REQ-010 SHALL have: idx_count_o  out  8  index count latched at job completion.
REQ-011 SHALL have: busy_o  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, START, WAIT, DONE, ERR; all outputs registered.
REQ-013 IDLE: if any req_i bit is high, SHALL select one round-robin, starting the search at (last granted index + 1) mod 4, and go to START.
REQ-014 Latency: req_i seen high in IDLE at cycle n -> gnt_o bit and sdr_control_o[0] high at cycle n+1.
REQ-015 START: SHALL last exactly 1 cycle with start high, then go to WAIT; clear the timeout counter.
REQ-016 WAIT: start SHALL stay high; the 16-bit timeout counter SHALL increment each cycle.
REQ-017 WAIT: sdr_status_i[31]=1 with bits 30/29 = 0 SHALL go to DONE and latch bits 7:0 into idx_count_o.
REQ-018 WAIT: bit30 or bit29 high SHALL go to ERR; this takes priority over bit31 in the same cycle.
REQ-019 WAIT: timeout_cfg_i!=0 and counter == timeout_cfg_i-1 SHALL go to ERR; the counter SHALL saturate and never wrap.
REQ-020 DONE/ERR: SHALL last 1 cycle; start low; gnt_o held; done_o or err_o pulsed for the grantee; then go to IDLE with gnt_o = 0.
REQ-021 Start SHALL be low for at least 2 cycles between jobs (DONE/ERR + IDLE); there are no back-to-back grants.
REQ-022 A grantee deasserting req_i mid-job SHALL be ignored; the job completes and the pulse is still issued.
REQ-023 Requests from non-granted requesters SHALL be ignored until IDLE; at most one gnt_o bit SHALL be high.
REQ-024 The round-robin pointer SHALL update only on entry to START.

Reset
REQ-025 Reset SHALL force: IDLE, gnt_o=0, done_o=0, err_o=0, sdr_control_o=0, idx_count_o=0, busy_o=0, pointer=3 (first search starts at requester 0), timeout counter=0.
REQ-026 Reset asserted mid-job SHALL drop start and grant immediately, with no done/err pulse.

Configuration
REQ-027 Macro SDR_SCHED_RETRY_EN defined: the first ERR of a job SHALL instead spend 1 cycle with start low and re-enter START, grant kept; a second failure SHALL go to ERR.
REQ-028 Macro SDR_SCHED_RETRY_EN undefined: any failure SHALL go directly to ERR; no retry logic is built.

Verification
REQ-029 Single request: req_i=0001, status[31] rises 10 cycles after start with idx=0x2A -> gnt_o=0001 at n+1, done_o[0] pulse, idx_count_o=0x2A, then gnt_o=0.
REQ-030 Round-robin: req_i=1111 held -> grants in order 0,1,2,3,0, with start low at least 2 cycles between jobs.
REQ-031 Timeout: timeout_cfg_i=5, status never done -> ERR after 5 WAIT cycles, err_o pulse; with RETRY_EN, err_o after the second attempt.
REQ-032 Error priority: status bits 31 and 30 both high in the same cycle -> err_o pulse, no done_o pulse, idx_count_o unchanged.
REQ-033 Reset mid-WAIT -> all outputs 0 next edge; after release, req_i=0100 -> gnt_o=0100.
REQ-034 timeout_cfg_i=0, done after 70000 cycles -> done_o pulse, no err_o pulse, counter saturated at 0xFFFF.

Source files
------------

// File: rtl/sdr_job_scheduler.sv
// ============================================================================
//  Module      : sdr_job_scheduler
//  Description : Round-robin arbiter that grants one of four requesters the
//                SDR register mux, runs a start/wait job and reports
//                done/error. Optional single retry on failure when
//                SDR_SCHED_RETRY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdr_job_scheduler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  req_i,
    output logic [3:0]  gnt_o,
    output logic [3:0]  done_o,
    output logic [3:0]  err_o,
    output logic [31:0] sdr_control_o,
    input  logic [31:0] sdr_status_i,
    input  logic [15:0] timeout_cfg_i,
    output logic [7:0]  idx_count_o,
    output logic        busy_o
);

    localparam int          NUM_REQ  = 4;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
`ifdef SDR_SCHED_RETRY_EN
        S_RETRY = 3'd5,
`endif
        S_ERR   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [3:0]  err_q, err_d;
    logic        start_q, start_d;
    logic [7:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
`ifdef SDR_SCHED_RETRY_EN
    logic        retried_q, retried_d;
`endif

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;

    logic        st_done;
    logic        st_fail;
    logic        tmo_hit;
    logic        unused_status;

    assign st_done = sdr_status_i[31];
    assign st_fail = sdr_status_i[30] | sdr_status_i[29];
    assign tmo_hit = (timeout_cfg_i != 16'd0) && (cnt_q == (timeout_cfg_i - 16'd1));

    assign unused_status = ^sdr_status_i[28:8];

    // Search begins one past the last grantee so every requester gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_valid && req_i[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 4'b0000;
        err_d     = 4'b0000;
        start_d   = 1'b0;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
`ifdef SDR_SCHED_RETRY_EN
        retried_d = retried_q;
`endif

        case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                if (pick_valid) begin
                    state_d   = S_START;
                    gnt_d     = 4'(1) << pick_idx;
                    start_d   = 1'b1;
                    ptr_d     = pick_idx;
`ifdef SDR_SCHED_RETRY_EN
                    retried_d = 1'b0;
`endif
                end
            end

            S_START: begin
                state_d = S_WAIT;
                start_d = 1'b1;
                cnt_d   = 16'd0;
            end

            S_WAIT: begin
                start_d = 1'b1;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
                // Error flags outrank a simultaneous done flag.
                if (st_fail || (!st_done && tmo_hit)) begin
                    start_d = 1'b0;
`ifdef SDR_SCHED_RETRY_EN
                    if (!retried_q) begin
                        state_d   = S_RETRY;
                        retried_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = gnt_q;
                    end
`else
                    state_d = S_ERR;
                    err_d   = gnt_q;
`endif
                end else if (st_done) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    done_d  = gnt_q;
                    idx_d   = sdr_status_i[7:0];
                end
            end

`ifdef SDR_SCHED_RETRY_EN
            S_RETRY: begin
                state_d = S_START;
                start_d = 1'b1;
            end
`endif

            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            gnt_q     <= 4'b0000;
            done_q    <= 4'b0000;
            err_q     <= 4'b0000;
            start_q   <= 1'b0;
            idx_q     <= 8'h00;
            busy_q    <= 1'b0;
            ptr_q     <= 2'd3;
            cnt_q     <= 16'd0;
`ifdef SDR_SCHED_RETRY_EN
            retried_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
`ifdef SDR_SCHED_RETRY_EN
            retried_q <= retried_d;
`endif
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign sdr_control_o = {31'd0, start_q};
    assign idx_count_o   = idx_q;
    assign busy_o        = busy_q;

endmodule

`default_nettype wire
